// File: rtl/dcache_store_unit.sv
// Retirement-side store engine: merges one retired store into its 8-byte line
// (D$ hit or memory fill), writes the line to the D$ and then through to memory.
module dcache_store_unit #(
  parameter  int DCACHE_LINES = 32,
  localparam int IDX_BITS     = $clog2(DCACHE_LINES),
  localparam int TAG_BITS     = 29 - IDX_BITS
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                st_valid,
  input  logic [31:0]         st_addr,
  input  logic [31:0]         st_data,
  input  logic [1:0]          st_size,
  output logic                store_in_progress,
  output logic                store_complete,
  output logic [IDX_BITS-1:0] dc_rd_idx,
  input  logic                dc_rd_valid,
  input  logic [TAG_BITS-1:0] dc_rd_tag,
  input  logic [63:0]         dc_rd_data,
  output logic                dc_wr_en,
  output logic [IDX_BITS-1:0] dc_wr_idx,
  output logic [TAG_BITS-1:0] dc_wr_tag,
  output logic [63:0]         dc_wr_data,
  output logic [1:0]          proc2mem_command,
  output logic [31:0]         proc2mem_addr,
  output logic [63:0]         proc2mem_data,
  input  logic                mem_grant,
  input  logic [3:0]          mem2proc_response,
  input  logic [63:0]         mem2proc_data,
  input  logic [3:0]          mem2proc_tag
);

  localparam logic [1:0] BUS_NONE  = 2'd0;
  localparam logic [1:0] BUS_LOAD  = 2'd1;
  localparam logic [1:0] BUS_STORE = 2'd2;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    LOAD_REQ,
    LOAD_WAIT,
    STORE_REQ,
    DONE
  } state_e;

  state_e        state_q, state_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   data_q, data_d;
  logic [1:0]    size_q, size_d;
  logic [63:0]   line_q, line_d;
  logic [3:0]    ld_tag_q, ld_tag_d;

  logic [2:0]          req_off;
  logic [IDX_BITS-1:0] req_idx;
  logic [TAG_BITS-1:0] req_tag;
  logic [63:0]         merge_base;
  logic [63:0]         merged;
  logic                hit;
  logic                accepted;
  logic                fill_match;

  assign req_off = addr_q[2:0];
  assign req_idx = addr_q[3 +: IDX_BITS];
  assign req_tag = addr_q[31 -: TAG_BITS];

  assign dc_rd_idx = req_idx;
  assign dc_wr_idx = req_idx;
  assign dc_wr_tag = req_tag;

  // Offset bits below the access size are dropped, so lanes are size-aligned.
  function automatic logic [63:0] mergeLine(input logic [63:0] base,
                                            input logic [2:0]  off,
                                            input logic [1:0]  size,
                                            input logic [31:0] data);
    logic [63:0] m;
    m = base;
    case (size)
      2'd0:    m[{off, 3'b000} +: 8]           = data[7:0];
      2'd1:    m[{off[2:1], 4'b0000} +: 16]    = data[15:0];
      default: m[{off[2], 5'b00000} +: 32]     = data[31:0];
    endcase
    return m;
  endfunction

  assign hit        = dc_rd_valid && (dc_rd_tag == req_tag);
  assign accepted   = mem_grant && (mem2proc_response != 4'd0);
  assign fill_match = (mem2proc_tag != 4'd0) && (mem2proc_tag == ld_tag_q);
  assign merge_base = (state_q == LOAD_WAIT) ? mem2proc_data : dc_rd_data;
  assign merged     = mergeLine(merge_base, req_off, size_q, data_q);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      data_q   <= '0;
      size_q   <= '0;
      line_q   <= '0;
      ld_tag_q <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      size_q   <= size_d;
      line_q   <= line_d;
      ld_tag_q <= ld_tag_d;
    end
  end

  always_comb begin
    state_d           = state_q;
    addr_d            = addr_q;
    data_d            = data_q;
    size_d            = size_q;
    line_d            = line_q;
    ld_tag_d          = ld_tag_q;
    store_in_progress = (state_q != IDLE);
    store_complete    = 1'b0;
    dc_wr_en          = 1'b0;
    dc_wr_data        = '0;
    proc2mem_command  = BUS_NONE;
    proc2mem_addr     = '0;
    proc2mem_data     = '0;

    case (state_q)
      IDLE: begin
        if (st_valid) begin
          addr_d  = st_addr;
          data_d  = st_data;
          size_d  = st_size;
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        if (hit) begin
          dc_wr_en   = 1'b1;
          dc_wr_data = merged;
          line_d     = merged;
          state_d    = STORE_REQ;
        end else begin
          state_d = LOAD_REQ;
        end
      end
      LOAD_REQ: begin
        proc2mem_command = BUS_LOAD;
        proc2mem_addr    = {addr_q[31:3], 3'b000};
        if (accepted) begin
          ld_tag_d = mem2proc_response;
          state_d  = LOAD_WAIT;
        end
      end
      LOAD_WAIT: begin
        // Write-allocate: the filled and merged line goes straight into the D$.
        if (fill_match) begin
          dc_wr_en   = 1'b1;
          dc_wr_data = merged;
          line_d     = merged;
          state_d    = STORE_REQ;
        end
      end
      STORE_REQ: begin
        proc2mem_command = BUS_STORE;
        proc2mem_addr    = {addr_q[31:3], 3'b000};
        proc2mem_data    = line_q;
        if (accepted) begin
          state_d = DONE;
        end
      end
      DONE: begin
        store_complete = 1'b1;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dcache_store_unit.sv
// Directed bench for dcache_store_unit: hit/miss merges, bus retry, reset abort.
module tb_dcache_store_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        st_valid;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [1:0]  st_size;
  logic        store_in_progress;
  logic        store_complete;
  logic [4:0]  dc_rd_idx;
  logic        dc_rd_valid;
  logic [23:0] dc_rd_tag;
  logic [63:0] dc_rd_data;
  logic        dc_wr_en;
  logic [4:0]  dc_wr_idx;
  logic [23:0] dc_wr_tag;
  logic [63:0] dc_wr_data;
  logic [1:0]  proc2mem_command;
  logic [31:0] proc2mem_addr;
  logic [63:0] proc2mem_data;
  logic        mem_grant;
  logic [3:0]  mem2proc_response;
  logic [63:0] mem2proc_data;
  logic [3:0]  mem2proc_tag;

  int checks   = 0;
  int failures = 0;

  dcache_store_unit #(.DCACHE_LINES(32)) dut (
    .clock(clock), .reset(reset),
    .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_size(st_size),
    .store_in_progress(store_in_progress), .store_complete(store_complete),
    .dc_rd_idx(dc_rd_idx), .dc_rd_valid(dc_rd_valid), .dc_rd_tag(dc_rd_tag),
    .dc_rd_data(dc_rd_data), .dc_wr_en(dc_wr_en), .dc_wr_idx(dc_wr_idx),
    .dc_wr_tag(dc_wr_tag), .dc_wr_data(dc_wr_data),
    .proc2mem_command(proc2mem_command), .proc2mem_addr(proc2mem_addr),
    .proc2mem_data(proc2mem_data), .mem_grant(mem_grant),
    .mem2proc_response(mem2proc_response), .mem2proc_data(mem2proc_data),
    .mem2proc_tag(mem2proc_tag)
  );

  always #5 clock = ~clock;

  task automatic cyc();
    @(negedge clock);
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] a,
                               input logic [31:0] d, input logic [1:0] s);
    st_valid = v;
    st_addr  = a;
    st_data  = d;
    st_size  = s;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    applyStimulus(1'b0, 32'h0, 32'h0, 2'd0);
    dc_rd_valid = 1'b0; dc_rd_tag = '0; dc_rd_data = '0;
    mem_grant = 1'b0; mem2proc_response = '0; mem2proc_data = '0; mem2proc_tag = '0;
    cyc(); cyc(); #1;
    checks++; if (store_in_progress !== 1'b0) begin failures++; $display("[TB] FAIL reset_sip got %b want 0", store_in_progress); end
    checks++; if (store_complete !== 1'b0) begin failures++; $display("[TB] FAIL reset_complete got %b want 0", store_complete); end
    checks++; if (dc_wr_en !== 1'b0) begin failures++; $display("[TB] FAIL reset_wr_en got %b want 0", dc_wr_en); end
    checks++; if (proc2mem_command !== 2'd0) begin failures++; $display("[TB] FAIL reset_cmd got %0d want 0", proc2mem_command); end
    checks++; if (proc2mem_addr !== 32'h0) begin failures++; $display("[TB] FAIL reset_addr got %h want 0", proc2mem_addr); end
    checks++; if (dc_rd_idx !== 5'd0 || dc_wr_data !== 64'h0 || proc2mem_data !== 64'h0) begin failures++; $display("[TB] FAIL reset_outputs idx=%h wdata=%h mdata=%h want all 0", dc_rd_idx, dc_wr_data, proc2mem_data); end
    reset = 1'b0;
    cyc();
  endtask

  task automatic test_hit_byte();
    dc_rd_valid = 1'b1; dc_rd_tag = 24'h0ABCDE; dc_rd_data = 64'h1122334455667788;
    applyStimulus(1'b1, 32'h0ABCDE11, 32'h000000AB, 2'd0); #1;
    checks++; if (store_in_progress !== 1'b0) begin failures++; $display("[TB] FAIL hit_c0_sip got %b want 0", store_in_progress); end
    cyc();
    applyStimulus(1'b0, 32'h0, 32'h0, 2'd0); #1;
    checks++; if (dc_wr_en !== 1'b1) begin failures++; $display("[TB] FAIL hit_wr_en got %b want 1", dc_wr_en); end
    checks++; if (dc_wr_data !== 64'h112233445566AB88) begin failures++; $display("[TB] FAIL hit_wr_data got %h want 112233445566ab88", dc_wr_data); end
    checks++; if (dc_wr_idx !== 5'd2 || dc_rd_idx !== 5'd2) begin failures++; $display("[TB] FAIL hit_idx wr=%0d rd=%0d want 2", dc_wr_idx, dc_rd_idx); end
    checks++; if (dc_wr_tag !== 24'h0ABCDE) begin failures++; $display("[TB] FAIL hit_wr_tag got %h want 0abcde", dc_wr_tag); end
    checks++; if (store_in_progress !== 1'b1 || proc2mem_command !== 2'd0) begin failures++; $display("[TB] FAIL hit_lookup sip=%b cmd=%0d want 1/0", store_in_progress, proc2mem_command); end
    cyc();
    mem_grant = 1'b1; mem2proc_response = 4'd1; #1;
    checks++; if (proc2mem_command !== 2'd2) begin failures++; $display("[TB] FAIL hit_cmd got %0d want 2", proc2mem_command); end
    checks++; if (proc2mem_addr !== 32'h0ABCDE10) begin failures++; $display("[TB] FAIL hit_maddr got %h want 0abcde10", proc2mem_addr); end
    checks++; if (proc2mem_data !== 64'h112233445566AB88) begin failures++; $display("[TB] FAIL hit_mdata got %h want 112233445566ab88", proc2mem_data); end
    checks++; if (dc_wr_en !== 1'b0 || store_complete !== 1'b0) begin failures++; $display("[TB] FAIL hit_storereq wr_en=%b complete=%b want 0/0", dc_wr_en, store_complete); end
    cyc();
    mem_grant = 1'b0; mem2proc_response = 4'd0; #1;
    checks++; if (store_complete !== 1'b1 || store_in_progress !== 1'b1) begin failures++; $display("[TB] FAIL hit_done complete=%b sip=%b want 1/1", store_complete, store_in_progress); end
    checks++; if (proc2mem_command !== 2'd0) begin failures++; $display("[TB] FAIL hit_done_cmd got %0d want 0", proc2mem_command); end
    cyc(); #1;
    checks++; if (store_in_progress !== 1'b0 || store_complete !== 1'b0) begin failures++; $display("[TB] FAIL hit_idle sip=%b complete=%b want 0/0", store_in_progress, store_complete); end
  endtask

  task automatic test_miss_word();
    dc_rd_valid = 1'b0; dc_rd_tag = 24'h0; dc_rd_data = 64'hFFFFFFFFFFFFFFFF;
    cyc();
    applyStimulus(1'b1, 32'h00001004, 32'hDEADBEEF, 2'd2);
    cyc();
    applyStimulus(1'b0, 32'h0, 32'h0, 2'd0); #1;
    checks++; if (dc_wr_en !== 1'b0 || proc2mem_command !== 2'd0) begin failures++; $display("[TB] FAIL miss_lookup wr_en=%b cmd=%0d want 0/0", dc_wr_en, proc2mem_command); end
    cyc();
    mem_grant = 1'b1; mem2proc_response = 4'd3; #1;
    checks++; if (proc2mem_command !== 2'd1 || proc2mem_addr !== 32'h00001000) begin failures++; $display("[TB] FAIL miss_loadreq cmd=%0d addr=%h want 1/00001000", proc2mem_command, proc2mem_addr); end
    cyc();
    mem_grant = 1'b0; mem2proc_response = 4'd0;
    for (int i = 0; i < 5; i++) begin
      if (i == 1) applyStimulus(1'b1, 32'hFFFF00F8, 32'h12345678, 2'd0);
      else        applyStimulus(1'b0, 32'h0, 32'h0, 2'd0);
      if (i == 2) begin mem2proc_tag = 4'd5; mem2proc_data = 64'hFFFFFFFFFFFFFFFF; end
      else        begin mem2proc_tag = 4'd0; mem2proc_data = 64'h0; end
      #1;
      checks++; if (dc_wr_en !== 1'b0 || proc2mem_command !== 2'd0 || dc_rd_idx !== 5'd0 || store_in_progress !== 1'b1) begin failures++; $display("[TB] FAIL miss_wait_%0d wr_en=%b cmd=%0d idx=%0d sip=%b want 0/0/0/1", i, dc_wr_en, proc2mem_command, dc_rd_idx, store_in_progress); end
      cyc();
    end
    applyStimulus(1'b0, 32'h0, 32'h0, 2'd0);
    mem2proc_tag = 4'd3; mem2proc_data = 64'h0; #1;
    checks++; if (dc_wr_en !== 1'b1 || dc_wr_data !== 64'hDEADBEEF00000000) begin failures++; $display("[TB] FAIL miss_fill wr_en=%b data=%h want 1/deadbeef00000000", dc_wr_en, dc_wr_data); end
    checks++; if (dc_wr_idx !== 5'd0 || dc_wr_tag !== 24'h000010) begin failures++; $display("[TB] FAIL miss_fill_loc idx=%0d tag=%h want 0/000010", dc_wr_idx, dc_wr_tag); end
    cyc();
    mem2proc_tag = 4'd0; mem_grant = 1'b1; mem2proc_response = 4'd2; #1;
    checks++; if (proc2mem_command !== 2'd2 || proc2mem_addr !== 32'h00001000 || proc2mem_data !== 64'hDEADBEEF00000000) begin failures++; $display("[TB] FAIL miss_store cmd=%0d addr=%h data=%h want 2/00001000/deadbeef00000000", proc2mem_command, proc2mem_addr, proc2mem_data); end
    cyc();
    mem_grant = 1'b0; mem2proc_response = 4'd0; #1;
    checks++; if (store_complete !== 1'b1) begin failures++; $display("[TB] FAIL miss_complete got %b want 1", store_complete); end
    cyc(); #1;
    checks++; if (store_in_progress !== 1'b0) begin failures++; $display("[TB] FAIL miss_idle sip got %b want 0", store_in_progress); end
  endtask

  task automatic test_reject();
    logic [1:0] gr [4];
    logic [3:0] rs [4];
    int pulses;
    gr = '{2'd0, 2'd0, 2'd1, 2'd1};
    rs = '{4'd1, 4'd2, 4'd0, 4'd4};
    dc_rd_valid = 1'b1; dc_rd_tag = 24'h000055; dc_rd_data = 64'h0123456789ABCDEF;
    cyc();
    applyStimulus(1'b1, 32'h00005518, 32'hCAFEF00D, 2'd3);
    cyc();
    applyStimulus(1'b0, 32'h0, 32'h0, 2'd0); #1;
    checks++; if (dc_wr_en !== 1'b1 || dc_wr_data !== 64'h01234567CAFEF00D) begin failures++; $display("[TB] FAIL rej_merge wr_en=%b data=%h want 1/01234567cafef00d", dc_wr_en, dc_wr_data); end
    cyc();
    for (int i = 0; i < 4; i++) begin
      mem_grant = gr[i][0]; mem2proc_response = rs[i]; #1;
      checks++; if (proc2mem_command !== 2'd2 || proc2mem_addr !== 32'h00005518 || proc2mem_data !== 64'h01234567CAFEF00D || store_complete !== 1'b0) begin failures++; $display("[TB] FAIL rej_hold_%0d cmd=%0d addr=%h data=%h complete=%b", i, proc2mem_command, proc2mem_addr, proc2mem_data, store_complete); end
      cyc();
    end
    mem_grant = 1'b0; mem2proc_response = 4'd0;
    pulses = 0;
    for (int k = 0; k < 3; k++) begin
      #1;
      if (store_complete === 1'b1) pulses++;
      cyc();
    end
    checks++; if (pulses !== 1) begin failures++; $display("[TB] FAIL rej_pulses got %0d want 1", pulses); end
    checks++; if (store_in_progress !== 1'b0) begin failures++; $display("[TB] FAIL rej_idle sip got %b want 0", store_in_progress); end
  endtask

  task automatic test_half_offset();
    dc_rd_valid = 1'b1; dc_rd_tag = 24'h000001; dc_rd_data = 64'h0;
    applyStimulus(1'b1, 32'h0000012F, 32'h0000BEEF, 2'd1);
    cyc();
    applyStimulus(1'b0, 32'h0, 32'h0, 2'd0); #1;
    checks++; if (dc_wr_en !== 1'b1 || dc_wr_data !== 64'hBEEF000000000000 || dc_wr_idx !== 5'd5) begin failures++; $display("[TB] FAIL half_merge wr_en=%b data=%h idx=%0d want 1/beef000000000000/5", dc_wr_en, dc_wr_data, dc_wr_idx); end
    cyc();
    mem_grant = 1'b1; mem2proc_response = 4'd1; #1;
    checks++; if (proc2mem_addr !== 32'h00000128 || proc2mem_data !== 64'hBEEF000000000000) begin failures++; $display("[TB] FAIL half_store addr=%h data=%h want 00000128/beef000000000000", proc2mem_addr, proc2mem_data); end
    cyc();
    mem_grant = 1'b0; mem2proc_response = 4'd0;
    cyc(); cyc();
  endtask

  task automatic test_reset_load_wait();
    dc_rd_valid = 1'b0; dc_rd_tag = 24'h0; dc_rd_data = 64'h0;
    applyStimulus(1'b1, 32'h00002000, 32'h00000077, 2'd0);
    cyc();
    applyStimulus(1'b0, 32'h0, 32'h0, 2'd0);
    cyc();
    mem_grant = 1'b1; mem2proc_response = 4'd7;
    cyc();
    mem_grant = 1'b0; mem2proc_response = 4'd0; #1;
    checks++; if (store_in_progress !== 1'b1 || proc2mem_command !== 2'd0) begin failures++; $display("[TB] FAIL rst_wait_state sip=%b cmd=%0d want 1/0", store_in_progress, proc2mem_command); end
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      mem2proc_tag = 4'd7; mem2proc_data = 64'hA5A5A5A5A5A5A5A5; #1;
      checks++; if (store_in_progress !== 1'b0 || dc_wr_en !== 1'b0 || store_complete !== 1'b0 || proc2mem_command !== 2'd0) begin failures++; $display("[TB] FAIL rst_abort_%0d sip=%b wr_en=%b complete=%b cmd=%0d want 0/0/0/0", i, store_in_progress, dc_wr_en, store_complete, proc2mem_command); end
      cyc();
    end
    mem2proc_tag = 4'd0; mem2proc_data = 64'h0;
  endtask

  task automatic test_back_to_back();
    dc_rd_valid = 1'b1; dc_rd_tag = 24'h0; dc_rd_data = 64'h0;
    applyStimulus(1'b1, 32'h00000020, 32'h00000011, 2'd0);
    cyc();
    applyStimulus(1'b0, 32'h0, 32'h0, 2'd0); #1;
    checks++; if (dc_wr_en !== 1'b1 || dc_wr_data !== 64'h0000000000000011) begin failures++; $display("[TB] FAIL b2b_first wr_en=%b data=%h want 1/11", dc_wr_en, dc_wr_data); end
    cyc();
    mem_grant = 1'b1; mem2proc_response = 4'd1;
    cyc();
    mem_grant = 1'b0; mem2proc_response = 4'd0;
    applyStimulus(1'b1, 32'h00000027, 32'h00000033, 2'd0); #1;
    checks++; if (store_complete !== 1'b1) begin failures++; $display("[TB] FAIL b2b_done got %b want 1", store_complete); end
    cyc();
    applyStimulus(1'b1, 32'h00000021, 32'h00000022, 2'd0); #1;
    checks++; if (store_in_progress !== 1'b0) begin failures++; $display("[TB] FAIL b2b_idle sip got %b want 0", store_in_progress); end
    cyc();
    applyStimulus(1'b0, 32'h0, 32'h0, 2'd0); #1;
    checks++; if (dc_wr_en !== 1'b1 || dc_wr_data !== 64'h0000000000002200) begin failures++; $display("[TB] FAIL b2b_second wr_en=%b data=%h want 1/2200", dc_wr_en, dc_wr_data); end
    cyc();
    mem_grant = 1'b1; mem2proc_response = 4'd1; #1;
    checks++; if (proc2mem_command !== 2'd2 || proc2mem_data !== 64'h0000000000002200) begin failures++; $display("[TB] FAIL b2b_store cmd=%0d data=%h want 2/2200", proc2mem_command, proc2mem_data); end
    cyc();
    mem_grant = 1'b0; mem2proc_response = 4'd0; #1;
    checks++; if (store_complete !== 1'b1) begin failures++; $display("[TB] FAIL b2b_complete got %b want 1", store_complete); end
    cyc(); #1;
    checks++; if (store_in_progress !== 1'b0) begin failures++; $display("[TB] FAIL b2b_end sip got %b want 0", store_in_progress); end
  endtask

  initial begin
    test_reset();
    test_hit_byte();
    test_miss_word();
    test_reject();
    test_half_offset();
    test_reset_load_wait();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
